datapath_ctrl: RTL and testbench

- Multicycle control FSM that drives the control inputs of the 16-bit datapath.
- Accepts one instruction per valid/ready handshake and decodes OpCode/OpCodeExt.
- Sequences the datapath register enables, mux selects and ALU op over 3–5 cycles.
- Runs a request/acknowledge handshake with data memory for LOAD/STOR, with a timeout.

---
 rtl/datapath_ctrl_if.sv | 28 ++
 rtl/datapath_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_datapath_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/datapath_ctrl_if.sv
// Instruction fetch and data memory handshake bundle for datapath_ctrl.
// master: instruction source / memory side; slave: the controller.
interface datapath_ctrl_if;
    logic [15:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;

    modport master (
        output instruction,
        output instr_valid,
        input  instr_ready,
        output mem_ack,
        input  mem_req,
        input  mem_we
    );

    modport slave (
        input  instruction,
        input  instr_valid,
        output instr_ready,
        input  mem_ack,
        output mem_req,
        output mem_we
    );
endinterface

// File: rtl/datapath_ctrl.sv
// Multicycle control FSM for the 16-bit datapath.
// Ports: clk, reset (async, active-low), bus (instr/mem handshakes),
// datapath enables/selects, illegal and mem_err pulses.
module datapath_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    datapath_ctrl_if.slave bus,
    output logic [3:0] aluControl,
    output logic       srcRegEn,
    output logic       dstRegEn,
    output logic       immRegEn,
    output logic       resultRegEn,
    output logic       regFileEn,
    output logic       signEn,
    output logic       irS,
    output logic [1:0] mux4En,
    output logic       regImmMuxEn,
    output logic       shiftALUMuxEn,
    output logic       exMemResultEn,
    output logic [1:0] regpcCont,
    output logic       pcRegEn,
    output logic       pcRegMuxEn,
    output logic       illegal,
    output logic       mem_err
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        WB,
        MEM,
        LDWB
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state;
    logic [15:0] ir;
    logic [7:0]  cnt;
    logic        run;
    logic        err_q;

    logic [3:0] op;
    logic [3:0] ext;
    logic [3:0] alu_sel;
    logic       rtype;
    logic       imm_op;
    logic       shift_op;
    logic       lshi;
    logic       mem_op;
    logic       store;
    logic       legal;
    logic       is_cmp;
    logic       ready;

    // Register/immediate fields go straight to the datapath.
    logic unused_fields;
    assign unused_fields = ^{ir[11:8], ir[3:0]};

    function automatic logic is_alu(input logic [3:0] c);
        return c inside {4'b0101, 4'b1001, 4'b1011, 4'b0001,
                         4'b0010, 4'b0011, 4'b1101};
    endfunction

    function automatic logic [3:0] alu_code(input logic [3:0] c);
        logic [3:0] r;
        r = 4'b0000;
        unique case (1'b1)
            c == 4'b0101: r = 4'b0000;
            c == 4'b1001: r = 4'b0001;
            c == 4'b0001: r = 4'b0010;
            c == 4'b0010: r = 4'b0011;
            c == 4'b0011: r = 4'b0100;
            c == 4'b1101: r = 4'b0101;
            c == 4'b1011: r = 4'b0110;
            default:      r = 4'b0000;
        endcase
        return r;
    endfunction

    always_comb begin
        op       = ir[15:12];
        ext      = ir[7:4];
        rtype    = (op == 4'b0000) && is_alu(ext);
        imm_op   = is_alu(op);
        lshi     = (op == 4'b1000) && (ext[3:1] == 3'b000);
        shift_op = lshi || ((op == 4'b1000) && (ext == 4'b0100));
        store    = (op == 4'b0100) && (ext == 4'b0100);
        mem_op   = store || ((op == 4'b0100) && (ext == 4'b0000));
        legal    = rtype || imm_op || shift_op || mem_op;
        alu_sel  = rtype ? ext : op;
        is_cmp   = (alu_sel == 4'b1011) && (rtype || imm_op);
    end

    // run keeps instr_ready low until the first edge after reset release.
    assign ready = run && (state == FETCH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            ir    <= '0;
            cnt   <= '0;
            run   <= 1'b0;
            err_q <= 1'b0;
        end else begin
            run   <= 1'b1;
            err_q <= 1'b0;
            case (state)
                FETCH: begin
                    if (bus.instr_valid && ready) begin
                        ir    <= bus.instruction;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (!legal)      state <= FETCH;
                    else if (mem_op) state <= MEM;
                    else             state <= EXEC;
                end
                EXEC: state <= WB;
                WB:   state <= FETCH;
                MEM: begin
                    // An ack on the final allowed cycle still wins.
                    if (bus.mem_ack) begin
                        cnt   <= '0;
                        state <= store ? FETCH : LDWB;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        err_q <= 1'b1;
                        state <= FETCH;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                LDWB:    state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    logic req;
    logic we;

    always_comb begin
        req           = 1'b0;
        we            = 1'b0;
        aluControl    = 4'b0000;
        srcRegEn      = 1'b0;
        dstRegEn      = 1'b0;
        immRegEn      = 1'b0;
        resultRegEn   = 1'b0;
        regFileEn     = 1'b0;
        signEn        = 1'b0;
        irS           = 1'b0;
        mux4En        = 2'b00;
        regImmMuxEn   = 1'b0;
        shiftALUMuxEn = 1'b0;
        exMemResultEn = 1'b0;
        regpcCont     = 2'b00;
        illegal       = 1'b0;
        case (state)
            DECODE: begin
                srcRegEn = 1'b1;
                dstRegEn = 1'b1;
                immRegEn = 1'b1;
                irS      = !(op inside {4'b0000, 4'b0100, 4'b1000});
                illegal  = !legal;
            end
            EXEC: begin
                resultRegEn = 1'b1;
                if (shift_op) begin
                    shiftALUMuxEn = 1'b1;
                    regImmMuxEn   = lshi;
                end else begin
                    aluControl = alu_code(alu_sel);
                    mux4En     = rtype ? 2'b00 : 2'b01;
                    signEn     = imm_op &&
                                 (op inside {4'b0101, 4'b1001, 4'b1011});
                end
            end
            WB:   regFileEn = !is_cmp;
            MEM: begin
                req = 1'b1;
                we  = store;
            end
            LDWB: begin
                regFileEn     = 1'b1;
                exMemResultEn = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.instr_ready = ready;
    assign bus.mem_req     = req;
    assign bus.mem_we      = we;
    assign pcRegEn         = 1'b0;
    assign pcRegMuxEn      = 1'b0;
    assign mem_err         = err_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed table-driven bench for datapath_ctrl.
// Drives at negedge, compares a packed output vector each cycle.
module tb_datapath_ctrl;

    logic clk;
    logic reset;

    datapath_ctrl_if bus();

    logic [3:0] aluControl;
    logic srcRegEn, dstRegEn, immRegEn, resultRegEn, regFileEn;
    logic signEn, irS, regImmMuxEn, shiftALUMuxEn, exMemResultEn;
    logic [1:0] mux4En, regpcCont;
    logic pcRegEn, pcRegMuxEn, illegal, mem_err;

    datapath_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave),
        .aluControl(aluControl),
        .srcRegEn(srcRegEn),
        .dstRegEn(dstRegEn),
        .immRegEn(immRegEn),
        .resultRegEn(resultRegEn),
        .regFileEn(regFileEn),
        .signEn(signEn),
        .irS(irS),
        .mux4En(mux4En),
        .regImmMuxEn(regImmMuxEn),
        .shiftALUMuxEn(shiftALUMuxEn),
        .exMemResultEn(exMemResultEn),
        .regpcCont(regpcCont),
        .pcRegEn(pcRegEn),
        .pcRegMuxEn(pcRegMuxEn),
        .illegal(illegal),
        .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [24:0] RDY = 25'h1 << 24;
    localparam logic [24:0] REQ = 25'h1 << 23;
    localparam logic [24:0] WE  = 25'h1 << 22;
    localparam logic [24:0] SRC = 25'h1 << 17;
    localparam logic [24:0] DST = 25'h1 << 16;
    localparam logic [24:0] IMM = 25'h1 << 15;
    localparam logic [24:0] RES = 25'h1 << 14;
    localparam logic [24:0] RF  = 25'h1 << 13;
    localparam logic [24:0] SGN = 25'h1 << 12;
    localparam logic [24:0] IRS = 25'h1 << 11;
    localparam logic [24:0] RIM = 25'h1 << 8;
    localparam logic [24:0] SHF = 25'h1 << 7;
    localparam logic [24:0] EXM = 25'h1 << 6;
    localparam logic [24:0] ILL = 25'h1 << 1;
    localparam logic [24:0] ERR = 25'h1 << 0;
    localparam logic [24:0] DEC = SRC | DST | IMM;

    function automatic logic [24:0] alu(input int v);
        return 25'(v) << 18;
    endfunction

    function automatic logic [24:0] mux(input int v);
        return 25'(v) << 9;
    endfunction

    logic [24:0] got;
    assign got = {bus.instr_ready, bus.mem_req, bus.mem_we, aluControl,
                  srcRegEn, dstRegEn, immRegEn, resultRegEn, regFileEn,
                  signEn, irS, mux4En, regImmMuxEn, shiftALUMuxEn,
                  exMemResultEn, regpcCont, pcRegEn, pcRegMuxEn,
                  illegal, mem_err};

    typedef struct {
        logic [15:0] instr;
        logic        valid;
        logic        ack;
        logic [24:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int checks;
    int errors;

    task automatic add(input logic [15:0] i, input logic v,
                       input logic a, input logic [24:0] e,
                       input string n);
        vec_t r;
        r.instr = i;
        r.valid = v;
        r.ack   = a;
        r.exp   = e;
        r.name  = n;
        vecs.push_back(r);
    endtask

    task automatic check(input string n, input logic [24:0] e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, e);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.instruction = 16'h0000;
        bus.instr_valid = 1'b0;
        bus.mem_ack = 1'b0;

        // ADD R3,R2, valid held high: DECODE ignores the new word
        add(16'h0352, 1, 0, RDY, "add_fetch");
        add(16'hF0F0, 1, 0, DEC, "add_dec");
        add(16'hF0F0, 1, 0, RES | alu(0) | mux(0), "add_exec");
        add(16'hF0F0, 1, 0, RF, "add_wb");
        // CMPI accepted back to back
        add(16'hB1F0, 1, 0, RDY, "cmpi_fetch");
        add(16'h0000, 0, 0, DEC | IRS, "cmpi_dec");
        add(16'h0000, 0, 0, RES | alu(6) | mux(1) | SGN, "cmpi_exec");
        add(16'h0000, 0, 0, '0, "cmpi_wb");
        // illegal ext; LOAD offered during DECODE is not taken
        add(16'hF0F0, 1, 0, RDY, "ill_fetch");
        add(16'h4302, 1, 0, DEC | IRS | ILL, "ill_dec");
        // LOAD, ack on the third MEM cycle
        add(16'h4302, 1, 0, RDY, "ld_fetch");
        add(16'h0000, 0, 0, DEC, "ld_dec");
        add(16'h0000, 0, 0, REQ, "ld_mem1");
        add(16'h0000, 0, 0, REQ, "ld_mem2");
        add(16'h0000, 0, 1, REQ, "ld_mem3");
        add(16'h0000, 0, 0, RF | EXM, "ld_wb");
        // STOR, no ack: timeout after 4 cycles
        add(16'h4342, 1, 0, RDY, "st_fetch");
        add(16'h0000, 0, 0, DEC, "st_dec");
        add(16'h0000, 0, 0, REQ | WE, "st_mem1");
        add(16'h0000, 0, 0, REQ | WE, "st_mem2");
        add(16'h0000, 0, 0, REQ | WE, "st_mem3");
        add(16'h0000, 0, 0, REQ | WE, "st_mem4");
        add(16'h0000, 0, 0, RDY | ERR, "st_err");
        // LSHI
        add(16'h8310, 1, 0, RDY, "lshi_fetch");
        add(16'h0000, 0, 0, DEC, "lshi_dec");
        add(16'h0000, 0, 0, RES | SHF | RIM, "lshi_exec");
        add(16'h0000, 0, 0, RF, "lshi_wb");
        // XORI: zero-extended immediate
        add(16'h3512, 1, 0, RDY, "xori_fetch");
        add(16'h0000, 0, 0, DEC | IRS, "xori_dec");
        add(16'h0000, 0, 0, RES | alu(4) | mux(1), "xori_exec");
        add(16'h0000, 0, 0, RF, "xori_wb");
        // STOR with ack on the last allowed cycle succeeds
        add(16'h4342, 1, 0, RDY, "st2_fetch");
        add(16'h0000, 0, 0, DEC, "st2_dec");
        add(16'h0000, 0, 0, REQ | WE, "st2_mem1");
        add(16'h0000, 0, 0, REQ | WE, "st2_mem2");
        add(16'h0000, 0, 0, REQ | WE, "st2_mem3");
        add(16'h0000, 0, 1, REQ | WE, "st2_mem4");
        add(16'h0000, 0, 0, RDY, "st2_done");
        // MOV R-type
        add(16'h00D1, 1, 0, RDY, "mov_fetch");
        add(16'h0000, 0, 0, DEC, "mov_dec");
        add(16'h0000, 0, 0, RES | alu(5) | mux(0), "mov_exec");
        add(16'h0000, 0, 0, RF, "mov_wb");
        add(16'h0000, 0, 0, RDY, "mov_done");

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_reset", '0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("after_reset", RDY);

        foreach (vecs[k]) begin
            if (k != 0) @(negedge clk);
            bus.instruction = vecs[k].instr;
            bus.instr_valid = vecs[k].valid;
            bus.mem_ack     = vecs[k].ack;
            #1;
            check(vecs[k].name, vecs[k].exp);
        end

        // reset in the middle of a memory access
        @(negedge clk);
        bus.instruction = 16'h4302;
        bus.instr_valid = 1'b1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        #1;
        check("mid_mem_req", REQ);
        reset = 1'b0;
        #1;
        check("async_reset", '0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_reset_rdy", RDY);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
